// File: rtl/pl_reg_elastic.sv
// pl_reg_elastic
//   Elastic inter-stage pipeline register (e.g. MEM->WB of the RV32 core).
//   Valid/ready handshake on both sides, optional skid entry so in_ready can
//   be a flop, flush, reg_write kill on bubbles, a forwarding tap and a
//   saturating stall counter.
// Ports
//   clk, reset (sync, active-low), flush (sync, active-high)
//   in_valid/in_ready + in_data/in_rd/in_reg_write/in_result_src  : upstream
//   out_valid/out_ready + out_data/out_rd/out_reg_write/out_result_src : downstream
//   fwd_en/fwd_rd/fwd_data : forwarding tap off the held entry
//   stall_cnt              : cycles spent with out_valid & !out_ready (saturating)
module pl_reg_elastic #(
  parameter int DATA_W = 160,
  parameter int RD_W   = 5,
  parameter int SEL_W  = 3,
  parameter int FWD_W  = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_reg_write,
  input  logic [SEL_W-1:0]  in_result_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_reg_write,
  output logic [SEL_W-1:0]  out_result_src,
  output logic              fwd_en,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [FWD_W-1:0]  fwd_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKIDF = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [RD_W-1:0]   main_rd_q,   main_rd_d,   skid_rd_q,   skid_rd_d;
  logic              main_rw_q,   main_rw_d,   skid_rw_q,   skid_rw_d;
  logic [SEL_W-1:0]  main_src_q,  main_src_d,  skid_src_q,  skid_src_d;
  // With SKID=1 this is the registered in_ready; with SKID=0 it only
  // marks "out of reset" and is gated with the combinational ready term.
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic in_fire, out_fire;

  always_comb begin
    if (SKID != 0) in_ready = reset & rdy_q;
    else           in_ready = reset & rdy_q & (~out_valid | out_ready);
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_rd_d   = main_rd_q;
    main_rw_d   = main_rw_q;
    main_src_d  = main_src_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    skid_rw_d   = skid_rw_q;
    skid_src_d  = skid_src_q;

    if (flush) begin
      // Drop everything held and anything offered this cycle.
      state_d     = ST_EMPTY;
      main_data_d = '0;
      main_rd_d   = '0;
      main_rw_d   = 1'b0;
      main_src_d  = '0;
      skid_data_d = '0;
      skid_rd_d   = '0;
      skid_rw_d   = 1'b0;
      skid_src_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d     = ST_FULL;
            main_data_d = in_data;
            main_rd_d   = in_rd;
            main_rw_d   = in_reg_write;
            main_src_d  = in_result_src;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_rd_d   = in_rd;
            main_rw_d   = in_reg_write;
            main_src_d  = in_result_src;
          end else if (in_fire && (SKID != 0)) begin
            // Downstream stalled: park the new entry behind the main one.
            state_d     = ST_SKIDF;
            skid_data_d = in_data;
            skid_rd_d   = in_rd;
            skid_rw_d   = in_reg_write;
            skid_src_d  = in_result_src;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKIDF: begin
          if (out_fire) begin
            state_d     = ST_FULL;
            main_data_d = skid_data_q;
            main_rd_d   = skid_rd_q;
            main_rw_d   = skid_rw_q;
            main_src_d  = skid_src_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // Ready for next cycle depends only on where we land, never on out_ready.
    rdy_d = (state_d != ST_SKIDF);

    stall_d = stall_q;
    if (out_valid && !out_ready && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_rd_q   <= '0;
      main_rw_q   <= 1'b0;
      main_src_q  <= '0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
      skid_rw_q   <= 1'b0;
      skid_src_q  <= '0;
      rdy_q       <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_rd_q   <= main_rd_d;
      main_rw_q   <= main_rw_d;
      main_src_q  <= main_src_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
      skid_rw_q   <= skid_rw_d;
      skid_src_q  <= skid_src_d;
      rdy_q       <= rdy_d;
      stall_q     <= stall_d;
    end
  end

  assign out_data       = main_data_q;
  assign out_rd         = main_rd_q;
  assign out_result_src = main_src_q;
  // Bubbles must never write the register file.
  assign out_reg_write  = out_valid & main_rw_q;
  assign fwd_en         = out_reg_write & (main_rd_q != '0);
  assign fwd_rd         = main_rd_q;
  assign fwd_data       = main_data_q[FWD_W-1:0];
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_pl_reg_elastic.sv
module tb_pl_reg_elastic;
  localparam int DW = 160, RW = 5, SW = 3, FW = 32, CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, out_ready, in_reg_write;
  logic [DW-1:0] in_data;
  logic [RW-1:0] in_rd;
  logic [SW-1:0] in_result_src;
  logic          in_ready, out_valid, out_reg_write, fwd_en;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_rd, fwd_rd;
  logic [SW-1:0] out_result_src;
  logic [FW-1:0] fwd_data;
  logic [CW-1:0] stall_cnt;

  pl_reg_elastic #(.DATA_W(DW), .RD_W(RW), .SEL_W(SW), .FWD_W(FW), .SKID(1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_result_src(in_result_src),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_result_src(out_result_src),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .stall_cnt(stall_cnt)
  );

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of capacity 2, ready next cycle iff it is not full.
  typedef struct {
    logic [DW-1:0] d;
    logic [RW-1:0] rd;
    logic          rw;
    logic [SW-1:0] src;
  } ent_t;

  ent_t mq[$];
  bit   m_rdy = 1'b0;
  int   m_cnt = 0;
  bit   known = 1'b0;

  always @(posedge clk) begin : model
    bit   inf, outf;
    ent_t e;
    inf  = in_valid && m_rdy && reset;
    outf = (mq.size() > 0) && out_ready;
    if (!reset) begin
      mq.delete();
      m_rdy = 1'b0;
      m_cnt = 0;
      known = 1'b1;
    end else begin
      if ((mq.size() > 0) && !out_ready && (m_cnt < (1 << CW) - 1)) m_cnt++;
      if (flush) mq.delete();
      else begin
        if (outf) void'(mq.pop_front());
        if (inf) begin
          e.d = in_data; e.rd = in_rd; e.rw = in_reg_write; e.src = in_result_src;
          mq.push_back(e);
        end
      end
      m_rdy = (mq.size() < 2);
    end
  end

  always @(negedge clk) begin : compare
    ent_t h;
    if (known) begin
      chk("in_ready", in_ready, m_rdy & reset);
      chk("out_valid", out_valid, mq.size() > 0);
      chk("stall_cnt", stall_cnt, m_cnt);
      if (mq.size() > 0) begin
        h = mq[0];
        chk("out_data", out_data, h.d);
        chk("out_rd", out_rd, h.rd);
        chk("out_reg_write", out_reg_write, h.rw);
        chk("out_result_src", out_result_src, h.src);
        chk("fwd_en", fwd_en, h.rw && (h.rd != 0));
        chk("fwd_rd", fwd_rd, h.rd);
        chk("fwd_data", fwd_data, h.d[FW-1:0]);
      end else begin
        chk("bubble_reg_write", out_reg_write, 1'b0);
        chk("bubble_fwd_en", fwd_en, 1'b0);
      end
    end
  end

  function automatic logic [DW-1:0] mk(input int n);
    return {32'(n + 4), 32'(n + 3), 32'(n + 2), 32'(n + 1), 32'(n)};
  endfunction

  task automatic step(input bit rst, input bit fl, input bit iv, input bit ordy,
                      input logic [DW-1:0] d, input logic [RW-1:0] rd, input bit rw);
    reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
    in_data = d; in_rd = rd; in_reg_write = rw; in_result_src = 3'(rd + 1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [DW-1:0] fwd_word;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_rd = '0; in_reg_write = 1'b0; in_result_src = '0;

    // Reset with traffic offered
    step(0, 0, 1, 1, mk(99), 5'd3, 1);
    step(0, 0, 1, 1, mk(99), 5'd3, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_fwd_en", fwd_en, 0);
    step(1, 0, 0, 1, '0, 5'd0, 0);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // Stream with no backpressure
    for (int k = 1; k <= 5; k++) begin
      step(1, 0, 1, 1, mk(k), 5'(k), 1);
      chk("stream_data", out_data, mk(k));
      chk("stream_valid", out_valid, 1);
    end
    step(1, 0, 0, 1, '0, 5'd0, 0);
    chk("stream_drain", out_valid, 0);
    chk("stream_stall", stall_cnt, 0);

    // Backpressure: A on output, B in skid, D offered but refused
    step(1, 0, 1, 0, mk(32'hA0), 5'd10, 1);
    chk("bp_A_out", out_data, mk(32'hA0));
    chk("bp_ready_full", in_ready, 1);
    step(1, 0, 1, 0, mk(32'hB0), 5'd11, 1);
    chk("bp_ready_skid", in_ready, 0);
    chk("bp_stall1", stall_cnt, 1);
    step(1, 0, 1, 0, mk(32'hD0), 5'd12, 1);
    step(1, 0, 1, 0, mk(32'hD0), 5'd12, 1);
    chk("bp_stall3", stall_cnt, 3);
    chk("bp_A_held", out_data, mk(32'hA0));
    step(1, 0, 0, 1, '0, 5'd0, 0);
    chk("bp_B_out", out_data, mk(32'hB0));
    chk("bp_ready_back", in_ready, 1);
    step(1, 0, 0, 1, '0, 5'd0, 0);
    chk("bp_drain", out_valid, 0);

    // Flush from SKIDF with C offered
    step(1, 0, 1, 0, mk(32'hE0), 5'd1, 1);
    step(1, 0, 1, 0, mk(32'hF0), 5'd2, 1);
    step(1, 1, 1, 0, mk(32'hC0), 5'd3, 1);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_stall_kept", stall_cnt, 5);
    step(1, 0, 0, 1, '0, 5'd0, 0);
    chk("fl_no_C", out_valid, 0);

    // Forwarding tap
    fwd_word = mk(7);
    fwd_word[31:0] = 32'hDEADBEEF;
    step(1, 0, 1, 1, fwd_word, 5'd5, 1);
    chk("fwd_en_rd5", fwd_en, 1);
    chk("fwd_rd5", fwd_rd, 5);
    chk("fwd_data", fwd_data, 32'hDEADBEEF);
    step(1, 0, 1, 1, fwd_word, 5'd0, 1);
    chk("fwd_en_rd0", fwd_en, 0);
    chk("rw_rd0", out_reg_write, 1);
    step(1, 0, 1, 1, fwd_word, 5'd7, 0);
    chk("fwd_en_norw", fwd_en, 0);
    step(1, 0, 0, 1, '0, 5'd0, 1);
    chk("bubble_rw", out_reg_write, 0);

    // Mixed random traffic, checked by the model every cycle
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom, $urandom},
           5'($urandom), $urandom_range(0, 1) == 1);

    // Saturation of the 4-bit stall counter
    step(0, 0, 0, 1, '0, 5'd0, 0);
    step(1, 0, 0, 1, '0, 5'd0, 0);
    chk("sat_start", stall_cnt, 0);
    step(1, 0, 1, 0, mk(77), 5'd4, 1);
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 0, 0, '0, 5'd0, 0);
      if (i == 14) chk("sat_14", stall_cnt, 14);
    end
    chk("sat_hold", stall_cnt, 15);
    chk("sat_data_held", out_data, mk(77));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
